// File: rtl/aes_dec_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, forward key expansion
// on a key change, inverse key schedule derived on the fly during the rounds.
package aes_pkg;
    typedef logic [127:0] aes_128;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

    // Entry b sits at bit (255-b)*8+7 downwards, i.e. {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction
endpackage

module aes_dec_iter #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  aes_pkg::aes_128 key_i,
    input  aes_pkg::aes_128 cipher_text_i,
    output aes_pkg::aes_128 plain_o,
    output logic            plain_ready_o,
    output logic            key_ready_o,
    output logic            busy_o
);
    import aes_pkg::*;

    typedef enum logic [2:0] {IDLE, KEYEXP, ADDK, ROUND, FINAL} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] ct_q, ct_d;
    logic [127:0] key_q, key_d;
    logic [127:0] rk10_q, rk10_d;
    logic [127:0] plain_q, plain_d;
    logic         plain_ready_q, plain_ready_d;
    logic         busy_q, busy_d;
    logic         key_ready_q, key_ready_d;

    logic [127:0] fwd_rk, inv_rk, inv_rows_sub;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = rk[127:96] ^ sub_rot(rk[31:0]) ^ {rc, 24'h0};
        w1 = rk[95:64] ^ w0;
        w2 = rk[63:32] ^ w1;
        w3 = rk[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one forward step: recover the previous round key from the current one.
    function automatic logic [127:0] inv_key_step(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = rk[31:0] ^ rk[63:32];
        w2 = rk[63:32] ^ rk[95:64];
        w1 = rk[95:64] ^ rk[127:96];
        w0 = rk[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [3:0][7:0] a, m9, m11, m13, m14;
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31 - 8*i -: 8];
            x2     = xt(a[i]);
            x4     = xt(x2);
            x8     = xt(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    // cnt_q holds the round index r; the inverse step for round r uses rcon[r+1].
    assign fwd_rk       = fwd_key_step(rk_q, rcon(cnt_q));
    assign inv_rk       = inv_key_step(rk_q, rcon(4'(cnt_q + 4'd1)));
    assign inv_rows_sub = inv_sub_bytes(inv_shift_rows(state_q));

    always_comb begin
        fsm_d         = fsm_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        rk_d          = rk_q;
        ct_d          = ct_q;
        key_d         = key_q;
        rk10_d        = rk10_q;
        plain_d       = plain_q;
        plain_ready_d = 1'b0;
        busy_d        = busy_q;
        key_ready_d   = key_ready_q;
        case (fsm_q)
            IDLE: begin
                if (start_i) begin
                    busy_d = 1'b1;
                    ct_d   = cipher_text_i;
                    if (KEY_CACHE && key_ready_q && (key_i == key_q)) begin
                        rk_d  = rk10_q;
                        fsm_d = ADDK;
                    end else begin
                        key_d       = key_i;
                        rk_d        = key_i;
                        key_ready_d = 1'b0;
                        cnt_d       = 4'd1;
                        fsm_d       = KEYEXP;
                    end
                end
            end
            KEYEXP: begin
                rk_d  = fwd_rk;
                cnt_d = 4'(cnt_q + 4'd1);
                if (cnt_q == 4'd10) begin
                    rk10_d      = fwd_rk;
                    key_ready_d = 1'b1;
                    fsm_d       = ADDK;
                end
            end
            ADDK: begin
                state_d = ct_q ^ rk_q;
                cnt_d   = 4'd9;
                fsm_d   = ROUND;
            end
            ROUND: begin
                rk_d    = inv_rk;
                state_d = inv_mix_columns(inv_rows_sub ^ inv_rk);
                cnt_d   = 4'(cnt_q - 4'd1);
                if (cnt_q == 4'd1) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                plain_d       = inv_rows_sub ^ inv_rk;
                plain_ready_d = 1'b1;
                busy_d        = 1'b0;
                fsm_d         = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q         <= IDLE;
            cnt_q         <= 4'd0;
            plain_q       <= '0;
            plain_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            key_ready_q   <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            cnt_q         <= cnt_d;
            plain_q       <= plain_d;
            plain_ready_q <= plain_ready_d;
            busy_q        <= busy_d;
            key_ready_q   <= key_ready_d;
        end
    end

    // Datapath registers carry no reset; key_ready_q guards the cache contents.
    always_ff @(posedge clk) begin
        state_q <= state_d;
        rk_q    <= rk_d;
        ct_q    <= ct_d;
        key_q   <= key_d;
        rk10_q  <= rk10_d;
    end

    assign plain_o       = plain_q;
    assign plain_ready_o = plain_ready_q;
    assign key_ready_o   = key_ready_q;
    assign busy_o        = busy_q;
endmodule

// File: tb/tb_aes_dec_iter.sv
// Directed bench for aes_dec_iter: known-answer vectors, latency, key cache,
// start-while-busy and mid-operation reset, on cached and uncached instances.
module tb_aes_dec_iter;
    logic         clk = 1'b0;
    logic         rst, start_i, start_nc;
    logic [127:0] key_i, ct_i;
    logic [127:0] plain, plain_nc;
    logic         rdy, rdy_nc, kr, kr_nc, busy, busy_nc;

    always #5 clk = ~clk;

    aes_dec_iter #(.KEY_CACHE(1'b1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .key_i(key_i), .cipher_text_i(ct_i),
        .plain_o(plain), .plain_ready_o(rdy), .key_ready_o(kr), .busy_o(busy));

    aes_dec_iter #(.KEY_CACHE(1'b0)) dut_nc (
        .clk(clk), .rst(rst), .start_i(start_nc), .key_i(key_i), .cipher_text_i(ct_i),
        .plain_o(plain_nc), .plain_ready_o(rdy_nc), .key_ready_o(kr_nc), .busy_o(busy_nc));

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] S1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] Q1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] S2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
    localparam logic [127:0] Q2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] S3 = 128'h43b1cd7f598ece23881b00e3ed030688;
    localparam logic [127:0] Q3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] S4 = 128'h7b0c785e27e8ad3f8223207104725dd4;
    localparam logic [127:0] Q4 = 128'hf69f2445df4f9b17ad2b417be66c3710;

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
        bit           b2b;
    } vec_t;

    vec_t vec [5];
    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [127:0] o_plain(input bit nc);
        return nc ? plain_nc : plain;
    endfunction
    function automatic logic o_rdy(input bit nc);
        return nc ? rdy_nc : rdy;
    endfunction
    function automatic logic o_kr(input bit nc);
        return nc ? kr_nc : kr;
    endfunction
    function automatic logic o_busy(input bit nc);
        return nc ? busy_nc : busy;
    endfunction

    // Called at a negedge; the next posedge is edge 0. Returns at the negedge after edge 0.
    task automatic launch(input bit nc, input logic [127:0] k, input logic [127:0] c,
                          input bit exp_kr, input string name);
        key_i = k;
        ct_i  = c;
        if (nc) start_nc = 1'b1;
        else    start_i  = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        start_nc = 1'b0;
        chk({name, " busy after edge0"}, 128'(o_busy(nc)), 128'd1);
        chk({name, " ready low after edge0"}, 128'(o_rdy(nc)), 128'd0);
        chk({name, " key_ready after edge0"}, 128'(o_kr(nc)), 128'(exp_kr));
    endtask

    task automatic wait_ready(input bit nc, input int lat_in, input bit watch_kr,
                              output int lat, output int kr_drops);
        lat      = lat_in;
        kr_drops = 0;
        while (!o_rdy(nc) && lat < 40) begin
            @(negedge clk);
            lat++;
            if (watch_kr && !o_kr(nc)) kr_drops++;
        end
    endtask

    task automatic finish_op(input bit nc, input logic [127:0] pt, input int exp_lat,
                             input int lat, input string name);
        chk({name, " latency"}, 128'(lat), 128'(exp_lat));
        chk({name, " plain"}, o_plain(nc), pt);
        chk({name, " busy low at ready"}, 128'(o_busy(nc)), 128'd0);
        chk({name, " key_ready at ready"}, 128'(o_kr(nc)), 128'd1);
    endtask

    initial begin
        int lat, drops, pulses, busy_seen;
        string nm;

        vec[0] = '{K1, C1, P1, 21, 1'b0};
        vec[1] = '{K2, S1, Q1, 21, 1'b0};
        vec[2] = '{K2, S2, Q2, 11, 1'b1};
        vec[3] = '{K2, S3, Q3, 11, 1'b1};
        vec[4] = '{K2, S4, Q4, 11, 1'b0};

        rst = 1'b1; start_i = 1'b0; start_nc = 1'b0; key_i = '0; ct_i = '0;
        repeat (3) @(negedge clk);
        chk("reset plain", plain, 128'd0);
        chk("reset ready", 128'(rdy), 128'd0);
        chk("reset key_ready", 128'(kr), 128'd0);
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset nc plain", plain_nc, 128'd0);
        chk("reset nc busy", 128'(busy_nc), 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer table: cold, key change, then back-to-back cached blocks
        for (int i = 0; i < 5; i++) begin
            nm = $sformatf("vec%0d", i);
            launch(1'b0, vec[i].key, vec[i].ct, vec[i].lat == 11, nm);
            wait_ready(1'b0, 0, vec[i].lat == 11, lat, drops);
            finish_op(1'b0, vec[i].pt, vec[i].lat, lat, nm);
            if (vec[i].lat == 11) chk({nm, " key_ready drops"}, 128'(drops), 128'd0);
            if (i == 4 || !vec[i+1].b2b) begin
                @(negedge clk);
                chk({nm, " ready one cycle"}, 128'(rdy), 128'd0);
                chk({nm, " plain held"}, plain, vec[i].pt);
            end
        end

        // Start pulse at edge 5 while busy must be ignored
        launch(1'b0, K2, S3, 1'b1, "busy");
        for (int n = 1; n < 5; n++) @(negedge clk);
        ct_i    = S1;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_ready(1'b0, 5, 1'b0, lat, drops);
        finish_op(1'b0, Q3, 11, lat, "busy");
        pulses    = 0;
        busy_seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rdy) pulses++;
            if (busy) busy_seen++;
        end
        chk("busy extra pulses", 128'(pulses), 128'd0);
        chk("busy no restart", 128'(busy_seen), 128'd0);
        chk("busy plain kept", plain, Q3);

        // Reset asserted so that it is sampled at edge 15 of a cold operation
        launch(1'b0, K1, C1, 1'b0, "rst");
        for (int n = 1; n < 15; n++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst plain", plain, 128'd0);
        chk("rst ready", 128'(rdy), 128'd0);
        chk("rst busy", 128'(busy), 128'd0);
        chk("rst key_ready", 128'(kr), 128'd0);
        rst    = 1'b0;
        pulses = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        chk("rst no pulse", 128'(pulses), 128'd0);
        launch(1'b0, K1, C1, 1'b0, "post-rst");
        wait_ready(1'b0, 0, 1'b0, lat, drops);
        finish_op(1'b0, P1, 21, lat, "post-rst");
        @(negedge clk);

        // Uncached instance: every start re-expands, even with an unchanged key
        launch(1'b1, K2, S1, 1'b0, "nc0");
        wait_ready(1'b1, 0, 1'b0, lat, drops);
        finish_op(1'b1, Q1, 21, lat, "nc0");
        launch(1'b1, K2, S2, 1'b0, "nc1");
        wait_ready(1'b1, 0, 1'b0, lat, drops);
        finish_op(1'b1, Q2, 21, lat, "nc1");
        @(negedge clk);
        chk("nc1 ready one cycle", 128'(rdy_nc), 128'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/aes_dec_iter.md
# aes_dec_iter

Iterative AES-128 inverse cipher (FIPS-197): one round per clock, forward key expansion on demand, inverse key schedule on the fly. It is the decrypt counterpart of the existing AES-128 encryptor and sits beside it in `aes_top`. It mirrors the encryptor's start/busy/ready handshake so both engines share one control shell. The final round key can be cached, so back-to-back blocks under the same key skip re-expansion.

## Interface
- `KEY_CACHE`, default 1: 1 keeps the round-10 key and skips expansion when the key is unchanged; 0 always expands.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start_i`  in  1  begin decrypting; sampled only in IDLE.
- `key_i`  in  128  cipher key (`aes_pkg::aes_128`); sampled with `start_i`.
- `cipher_text_i`  in  128  ciphertext block; sampled with `start_i`.
- `plain_o`  out  128  plaintext; registered, holds until the next completion.
- `plain_ready_o`  out  1  one-cycle pulse, `plain_o` valid.
- `key_ready_o`  out  1  cached round-10 key valid for the stored key.
- `busy_o`  out  1  operation in progress; `start_i` ignored.

## Operation
- Byte order: byte 0 = bits [127:120]; state is column-major per FIPS-197.
- S-box and inverse S-box come from `aes_pkg`. Rcon sequence is 01,02,04,08,10,20,40,80,1b,36.
- FSM states:
  - IDLE
    - On `start_i`: latch ciphertext and set `busy_o`.
    - If `KEY_CACHE`, `key_ready_o`, and `key_i` equals the stored key: set `rk` to the cached rk10 and go to ADDK.
    - Otherwise: store `key_i`, set `rk <= key_i`, clear `key_ready_o`, and go to KEYEXP.
  - KEYEXP: 10 cycles of the forward schedule. On the 10th cycle, write rk10 to the cache, set `key_ready_o`, and go to ADDK.
  - ADDK: `state <= ct ^ rk10`; go to ROUND.
  - ROUND: 9 cycles, r = 9 down to 1.
    - Inverse key step: w3'=w7^w6, w2'=w6^w5, w1'=w5^w4, w0'=w4^SubWord(RotWord(w3'))^rcon[r+1].
    - `state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_r)`.
  - FINAL: one more inverse key step gives rk0.
    - `plain_o <= InvSubBytes(InvShiftRows(state)) ^ rk0`.
    - Pulse `plain_ready_o`, clear `busy_o`, return to IDLE.
- `start_i` held high stays inert while busy. If it is still high in IDLE after completion, a new operation starts on that edge.
- With `KEY_CACHE`=0, `key_ready_o` still rises after KEYEXP but is never used to skip.

## Timing
- Reset: every output is 0, FSM is IDLE, cache is invalid, `plain_o` is 0.
- Cold key: start is sampled at edge 0.
  - Edges 1–10: KEYEXP. `key_ready_o` rises after edge 10.
  - Edge 11: ADDK. Edges 12–20: ROUND. Edge 21: FINAL.
  - `plain_ready_o` is high for the cycle after edge 21.
- Cached key:
  - Edge 1: ADDK. Edges 2–10: ROUND. Edge 11: FINAL.
  - `plain_ready_o` is high for the cycle after edge 11.
- `busy_o` rises after edge 0. It falls on the same edge that `plain_ready_o` rises, so a new start can be accepted the cycle `plain_ready_o` is high.
- `key_ready_o` falls after edge 0 of a start with a different key.
- `rst` mid-operation: return to IDLE next edge and apply all reset values.
  - The cache is invalidated.
  - No `plain_ready_o` is produced for the aborted block.

## Test plan
- FIPS-197 C.1 decrypt, cold key:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: `plain_o` 00112233445566778899aabbccddeeff, `plain_ready_o` after edge 21, exactly one cycle wide.
- SP800-38A ECB block 1, cold key:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3ad77bb40d7a3660a89ecaf32466ef97.
  - Response: pt 6bc1bee22e409f96e93d7e117393172a.
- Same key, back-to-back:
  - Stimulus: restart in the `plain_ready_o` cycle with ct f5d3d58503b9699de785895a96fdbaaf.
  - Response: pt ae2d8a571e03ac9c9eb76fac45af8e51 after 11 edges; `key_ready_o` stays 1 throughout.
- Key change:
  - Stimulus: after the C.1 key, start with the SP800-38A key.
  - Response: `key_ready_o` drops, a full 21-edge latency, then the correct pt.
  - Repeat with `KEY_CACHE`=0: every start takes 21 edges.
- Start while busy: pulse `start_i` at edge 5 with a different ct.
  - Response: ignored; the original result is unchanged and only one `plain_ready_o` pulse occurs.
- Reset at edge 15 of an operation:
  - Response: all outputs 0 the next cycle and no `plain_ready_o` pulse.
  - A following start with the same key takes the cold 21-edge path.
